sha256_hash_compress: RTL
=========================

Name: sha256_hash_compress

Overview:
- Downstream consumer of sha256_message_build. Takes padded 512-bit message blocks, runs the 64-round SHA-256 compression one round per cycle, and accumulates the intermediate hash H0..H7 across blocks.
- On the block flagged last, it emits the 256-bit digest on a valid/ready output, then re-arms with the initial hash value (IV) for the next message.

Parameters:
- none. SHA-256 constants are fixed in the shared package.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  global enable; low freezes all state
- sync_rst  in  1  synchronous reset; returns block to IDLE with H=IV
- data_in  in  512  message block; word0 = data_in[511:480] (big-endian word order)
- data_in_last  in  1  block is the final block of its message
- data_in_valid  in  1  block valid
- data_in_ready  out  1  block accepted when valid&&ready
- data_out  out  256  digest; H0 in [255:224] … H7 in [31:0]
- data_out_valid  out  1  digest valid
- data_out_ready  in  1  downstream accepts digest

Behaviour:
- Reset is nrst, asynchronous, active-low; clock is clk.
- Reset values:
  - state=IDLE, H=IV, a..h=0, round counter=0, last_flag=0, window=0.
  - data_out=0, data_out_valid=0.
  - data_in_ready is combinational: (state==IDLE)&&en. It is therefore 1 during reset if en=1.
- Priority at each edge: nrst > sync_rst > !en > normal operation.
  - sync_rst: same state as reset. Any in-flight block and any pending digest are discarded.
  - en low: no register changes; data_out_valid/data_out held.
- FSM states: IDLE, ROUND, UPDATE, DONE.
- IDLE, on data_in handshake:
  - a..h <= H0..H7.
  - 16-word window <= block.
  - t <= 0; last_flag <= data_in_last.
  - -> ROUND.
- ROUND, each cycle with t = 0..63:
  - T1 = h+Σ1(e)+Ch(e,f,g)+K[t]+W_t; T2 = Σ0(a)+Maj(a,b,c). All sums mod 2^32.
  - Register shift: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - W_t = window[0]. Window shifts left one word and appends W_{t+16} = σ1(W[14])+W[9]+σ0(W[1])+W[0].
  - t increments. At t==63 -> UPDATE.
- UPDATE (1 cycle):
  - Hi <= Hi + var_i, mod 2^32 per word.
  - If last_flag: data_out <= updated H; data_out_valid <= 1; H <= IV; -> DONE.
  - Else -> IDLE.
- DONE: hold data_out/data_out_valid until data_out_ready, then valid <= 0 -> IDLE. No new block is accepted while in DONE (ready=0).
- Latency:
  - Input handshake at edge E. Rounds occupy edges E+1..E+64, UPDATE at E+65.
  - data_out_valid high after edge E+65 → visible 65 cycles after the accepting edge.
  - Non-last block: ready re-asserts after E+65.
  - Throughput: 1 block per 66 cycles.
- data_out stays stable while valid&&!ready. data_out keeps its last value after the handshake.
- data_in_valid while busy is ignored and not latched; the upstream must hold data.
- Empty message: a single padded block is handled like any other last block.

Decomposition:
- Package sha256_pkg:
  - K[0:63] constant array and IV[0:7] constant array.
  - word_t typedef (logic[31:0]) and state enum.
  - Functions: Ch, Maj, Σ0, Σ1, σ0, σ1.
- Sub-module sha256_message_schedule holds the 16-word window.
  - Inputs: load, block, shift.
  - Output: W_t.
- The compression FSM and datapath stay in sha256_hash_compress.

Test Plan:
- "abc" single block: data_in = 61626380 followed by 0…0 with last word 00000018, last=1, out_ready=1 -> data_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, valid 65 cycles after handshake.
- Empty message: block = 80000000 followed by 0s, last=1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits), blocks with last=0 then last=1 and a 5-cycle valid gap between them -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Exactly one output beat; ready low during both compressions.
- Back-pressure: data_out_ready held 0 for 20 cycles after "abc" completes, then "abc" block presented again -> data_out stable, data_in_ready=0 throughout the stall. After the handshake, the second digest equals the first (IV re-armed).
- en toggled low for 10 cycles mid-ROUND, then "abc" continues -> correct digest, valid delayed by exactly 10 cycles.
- sync_rst pulsed at round 30 of a first block, then "abc" sent -> no output from the aborted block; next digest = abc reference.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and bit-mixing functions.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        UPDATE,
        DONE
    } state_e;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_message_schedule.sv
// 16-word sliding message schedule window; w_t is the word consumed by the current round.
module sha256_message_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block,
    output logic [31:0]  w_t
);

    word_t win_q [16];
    word_t win_d [16];
    word_t w_next;

    // Next window: clear, load a fresh block, or slide left appending W[t+16].
    always_comb begin
        w_next = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
        win_d  = win_q;
        if (clr) begin
            win_d = '{default: '0};
        end else if (load) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win_d[i] = block[511 - 32*i -: 32];
            end
        end else if (shift) begin
            for (int unsigned i = 0; i < 15; i++) begin
                win_d[i] = win_q[i + 1];
            end
            win_d[15] = w_next;
        end
    end

    // Window register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            win_q <= '{default: '0};
        end else begin
            win_q <= win_d;
        end
    end

    assign w_t = win_q[0];

endmodule

// File: rtl/sha256_hash_compress.sv
// SHA-256 compression: one round per cycle, hash chaining across blocks, digest on valid/ready.
module sha256_hash_compress
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic         en,
    input  logic         sync_rst,
    input  logic [511:0] data_in,
    input  logic         data_in_last,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [255:0] data_out,
    output logic         data_out_valid,
    input  logic         data_out_ready
);

    state_e       state_q, state_d;
    word_t        h_q [8];
    word_t        h_d [8];
    word_t        v_q [8];
    word_t        v_d [8];
    word_t        h_sum [8];
    logic [5:0]   t_q, t_d;
    logic         last_q, last_d;
    logic [255:0] dout_q, dout_d;
    logic         dout_valid_q, dout_valid_d;
    word_t        w_t, t1, t2;
    logic         accept;

    assign data_in_ready  = (state_q == IDLE) && en;
    assign accept         = data_in_ready && data_in_valid;
    assign data_out       = dout_q;
    assign data_out_valid = dout_valid_q;

    sha256_message_schedule u_sched (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (sync_rst),
        .load  (accept),
        .shift (en && (state_q == ROUND)),
        .block (data_in),
        .w_t   (w_t)
    );

    // Round function, hash update and FSM next-state; v_q[0..7] hold working vars a..h.
    always_comb begin
        t1 = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + K[t_q] + w_t;
        t2 = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
        for (int unsigned i = 0; i < 8; i++) begin
            h_sum[i] = h_q[i] + v_q[i];
        end
        state_d      = state_q;
        h_d          = h_q;
        v_d          = v_q;
        t_d          = t_q;
        last_d       = last_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (sync_rst) begin
            state_d      = IDLE;
            h_d          = IV;
            v_d          = '{default: '0};
            t_d          = '0;
            last_d       = 1'b0;
            dout_d       = '0;
            dout_valid_d = 1'b0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        v_d     = h_q;
                        t_d     = '0;
                        last_d  = data_in_last;
                        state_d = ROUND;
                    end
                end
                ROUND: begin
                    v_d[7] = v_q[6];
                    v_d[6] = v_q[5];
                    v_d[5] = v_q[4];
                    v_d[4] = v_q[3] + t1;
                    v_d[3] = v_q[2];
                    v_d[2] = v_q[1];
                    v_d[1] = v_q[0];
                    v_d[0] = t1 + t2;
                    t_d    = t_q + 6'd1;
                    if (t_q == 6'd63) begin
                        state_d = UPDATE;
                    end
                end
                UPDATE: begin
                    if (last_q) begin
                        dout_d       = {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                                        h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
                        dout_valid_d = 1'b1;
                        h_d          = IV;
                        state_d      = DONE;
                    end else begin
                        h_d     = h_sum;
                        state_d = IDLE;
                    end
                end
                DONE: begin
                    if (data_out_ready) begin
                        dout_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            h_q          <= IV;
            v_q          <= '{default: '0};
            t_q          <= '0;
            last_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            t_q          <= t_d;
            last_q       <= last_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

endmodule
